// File: rtl/ysyx_23060096_imm_pkg.sv
// rtl/ysyx_23060096_imm_pkg.sv - format encodings and buffer occupancy states for the immediate unit
package ysyx_23060096_imm_pkg;

  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_U     = 3'b001,
    FMT_S     = 3'b010,
    FMT_B     = 3'b011,
    FMT_J     = 3'b100,
    FMT_SHAMT = 3'b101,
    FMT_ZIMM  = 3'b110,
    FMT_RSV   = 3'b111
  } fmt_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/ysyx_23060096_imm_decode.sv
// rtl/ysyx_23060096_imm_decode.sv - combinational immediate extraction and extension to XLEN
module ysyx_23060096_imm_decode
  import ysyx_23060096_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            fmtErr
);

  // raw is the 32-bit form; signExt selects how bit 31 spreads into a 64-bit datapath
  logic [31:0] raw;
  logic        signExt;

  always_comb begin
    raw     = '0;
    signExt = 1'b1;
    fmtErr  = 1'b0;
    case (fmt)
      FMT_I:     raw = {{20{inst[31]}}, inst[31:20]};
      FMT_U:     raw = {inst[31:12], 12'b0};
      FMT_S:     raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:     raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_J:     raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_SHAMT: begin
        signExt = 1'b0;
        raw     = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
      end
      FMT_ZIMM:  begin
        signExt = 1'b0;
        raw     = {27'b0, inst[19:15]};
      end
      default:   begin
        signExt = 1'b0;
        fmtErr  = 1'b1;
      end
    endcase
  end

  always_comb begin
    if (signExt) imm = XLEN'($signed(raw));
    else         imm = XLEN'(raw);
  end

endmodule

// File: rtl/ysyx_23060096_imm_unit.sv
// rtl/ysyx_23060096_imm_unit.sv - immediate generator with 2-entry skid buffer, flush and tag pass-through
module ysyx_23060096_imm_unit
  import ysyx_23060096_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_fmt_err,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  decImm;
  logic             decErr;
  logic [XLEN-1:0]  skidImm;
  logic             skidErr;
  logic [TAG_W-1:0] skidTag;
  occ_e             state;
  occ_e             nextState;
  logic             accept;
  logic             pop;
  logic             loadMainIn;
  logic             loadMainSkid;
  logic             loadSkid;
  logic             unusedInstLow;

  // opcode bits never contribute to an immediate
  assign unusedInstLow = ^in_inst[6:0];

  ysyx_23060096_imm_decode #(.XLEN(XLEN)) uDecode (
    .inst   (in_inst[31:7]),
    .fmt    (in_fmt),
    .imm    (decImm),
    .fmtErr (decErr)
  );

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    nextState    = state;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          nextState  = ONE;
          loadMainIn = 1'b1;
        end
        ONE: begin
          if (accept && pop) begin
            loadMainIn = 1'b1;
          end else if (accept) begin
            nextState = FULL;
            loadSkid  = 1'b1;
          end else if (pop) begin
            nextState = EMPTY;
          end
        end
        FULL: if (pop) begin
          nextState    = ONE;
          loadMainSkid = 1'b1;
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready    <= 1'b1;
      out_imm     <= '0;
      out_fmt_err <= 1'b0;
      out_tag     <= '0;
      skidImm     <= '0;
      skidErr     <= 1'b0;
      skidTag     <= '0;
    end else begin
      state    <= nextState;
      // registered copy of the next occupancy keeps out_ready off the in_ready path
      in_ready <= (nextState != FULL);
      if (loadMainIn) begin
        out_imm     <= decImm;
        out_fmt_err <= decErr;
        out_tag     <= in_tag;
      end else if (loadMainSkid) begin
        out_imm     <= skidImm;
        out_fmt_err <= skidErr;
        out_tag     <= skidTag;
      end
      if (loadSkid) begin
        skidImm <= decImm;
        skidErr <= decErr;
        skidTag <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060096_imm_unit.sv
// tb/tb_ysyx_23060096_imm_unit.sv - self-checking bench for the immediate unit at XLEN 32 and 64
module tb_ysyx_23060096_imm_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_fmt;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid, out_fmt_err;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;
  logic        in_ready64, out_valid64, out_fmt_err64;
  logic [63:0] out_imm64;
  logic [4:0]  out_tag64;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  ysyx_23060096_imm_unit #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_fmt_err(out_fmt_err), .out_tag(out_tag)
  );

  ysyx_23060096_imm_unit #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_fmt_err(out_fmt_err64), .out_tag(out_tag64)
  );

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [31:0] exp32;
    logic [63:0] exp64;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
    logic [4:0]  tag;
  } beat_t;

  vec_t  vecs[10];
  beat_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Immediate value as a signed integer, derived field by field from the ISA encoding
  function automatic longint refVal(input logic [31:0] inst, input logic [2:0] fmt, input bit is64);
    longint f;
    case (fmt)
      3'd0: begin f = longint'(inst[31:20]); if (f >= 2048) f -= 4096; end
      3'd1: begin f = longint'(inst[31:12]) * 4096; if (inst[31]) f -= 64'sd4294967296; end
      3'd2: begin f = longint'(inst[31:25]) * 32 + longint'(inst[11:7]); if (f >= 2048) f -= 4096; end
      3'd3: begin
        f = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
          + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
        if (f >= 4096) f -= 8192;
      end
      3'd4: begin
        f = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
          + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
        if (f >= 1048576) f -= 2097152;
      end
      3'd5: f = is64 ? longint'(inst[25:20]) : longint'(inst[24:20]);
      3'd6: f = longint'(inst[19:15]);
      default: f = 0;
    endcase
    return f;
  endfunction

  task automatic fillFull(input logic [4:0] t0, input logic [4:0] t1);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_fmt = 3'd0;
    in_inst = 32'h00500093; in_tag = t0;
    @(negedge clk);
    in_inst = 32'h00600093; in_tag = t1;
    @(negedge clk);
    in_valid = 1'b0;
    check("fill_in_ready_low", {63'b0, in_ready}, 64'd0);
  endtask

  initial begin
    longint v;
    beat_t  b;
    vecs[0] = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1] = '{32'h7FF00093, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vecs[2] = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3] = '{32'h12345678, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[4] = '{32'h800000B7, 3'd1, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[5] = '{32'h03F09093, 3'd5, 32'h0000001F, 64'h000000000000003F, 1'b0};
    vecs[6] = '{32'hFE112E23, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[7] = '{32'h0080006F, 3'd4, 32'h00000008, 64'h0000000000000008, 1'b0};
    vecs[8] = '{32'h000FD073, 3'd6, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vecs[9] = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_fmt = '0;
    in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_imm", {32'b0, out_imm}, 64'd0);
    check("rst_out_fmt_err", {63'b0, out_fmt_err}, 64'd0);
    check("rst_out_tag", {59'b0, out_tag}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_inst = vecs[i].inst; in_fmt = vecs[i].fmt;
      in_tag = 5'(i); out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), {63'b0, out_valid}, 64'd1);
      check($sformatf("vec%0d_imm32", i), {32'b0, out_imm}, {32'b0, vecs[i].exp32});
      check($sformatf("vec%0d_imm64", i), out_imm64, vecs[i].exp64);
      check($sformatf("vec%0d_err", i), {63'b0, out_fmt_err}, {63'b0, vecs[i].err});
      check($sformatf("vec%0d_tag", i), {59'b0, out_tag}, 64'(i));
    end

    // backpressure: tags 1,2 fill the buffer, tag 3 waits, then all drain in order
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_fmt = 3'd0; in_inst = 32'h00100093; in_tag = 5'd1;
    @(negedge clk);
    check("bp_ready_after_first", {63'b0, in_ready}, 64'd1);
    in_inst = 32'h00200093; in_tag = 5'd2;
    @(negedge clk);
    check("bp_ready_low", {63'b0, in_ready}, 64'd0);
    in_inst = 32'h00300093; in_tag = 5'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_stall_tag", {59'b0, out_tag}, 64'd1);
      check("bp_stall_imm", {32'b0, out_imm}, 64'd1);
      check("bp_stall_ready", {63'b0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_tag2", {59'b0, out_tag}, 64'd2);
    check("bp_ready_rise", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_tag3", {59'b0, out_tag}, 64'd3);
    check("bp_imm3", {32'b0, out_imm}, 64'd3);
    @(negedge clk);
    check("bp_drained", {63'b0, out_valid}, 64'd0);

    // flush while FULL with a simultaneous offer and pop
    fillFull(5'd5, 5'd6);
    flush = 1'b1; in_valid = 1'b1; in_tag = 5'd7; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    check("flush_in_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    check("flush_nothing_later", {63'b0, out_valid | out_valid64}, 64'd0);

    // asynchronous reset mid-burst while FULL
    fillFull(5'd8, 5'd9);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {63'b0, out_valid}, 64'd0);
    check("arst_in_ready", {63'b0, in_ready}, 64'd1);
    check("arst_out_imm", out_imm64, 64'd0);
    check("arst_out_tag", {59'b0, out_tag}, 64'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00093; in_fmt = 3'd0;
    in_tag = 5'd10; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("arst_first_valid", {63'b0, out_valid}, 64'd1);
    check("arst_first_tag", {59'b0, out_tag}, 64'd10);
    check("arst_first_imm", {32'b0, out_imm}, 64'hFFFFFFFF);
    @(negedge clk);
    check("arst_first_drained", {63'b0, out_valid}, 64'd0);

    // randomized traffic against a scoreboard queue
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      check("rnd_out_valid", {63'b0, out_valid}, {63'b0, sb.size() != 0});
      check("rnd_in_ready", {63'b0, in_ready}, {63'b0, sb.size() < 2});
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_inst  = $urandom;
        in_fmt   = 3'($urandom_range(0, 7));
        in_tag   = 5'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          b = sb.pop_front();
          check("rnd_tag", {59'b0, out_tag}, {59'b0, b.tag});
          check("rnd_imm32", {32'b0, out_imm}, {32'b0, b.e32});
          check("rnd_imm64", out_imm64, b.e64);
          check("rnd_err", {62'b0, out_fmt_err, out_fmt_err64}, {62'b0, b.err, b.err});
        end
        if (in_valid && in_ready) begin
          v = refVal(in_inst, in_fmt, 1'b0);
          b.e32 = v[31:0];
          v = refVal(in_inst, in_fmt, 1'b1);
          b.e64 = v;
          b.err = (in_fmt == 3'd7);
          b.tag = in_tag;
          sb.push_back(b);
        end
      end
    end

    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      if (out_valid) begin
        b = sb.pop_front();
        check("drain_tag", {59'b0, out_tag}, {59'b0, b.tag});
        check("drain_imm64", out_imm64, b.e64);
      end
      @(negedge clk);
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("drain_out_valid", {63'b0, out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
